redun_sq_loop: RTL and testbench

- Iteration controller that sits directly upstream of redun_mont and also consumes its output.
- Accepts a starting value in Montgomery/redundant form plus an iteration count T. It issues the value to redun_mont and feeds each o_mul back into i_sq until T squarings have completed.
- It then carry-resolves the final redundant result into a plain binary word and presents it downstream with a valid/ready handshake.
- It replaces the testbench-driven feedback loop with synthesizable control.

---
 rtl/redun_sq_loop.sv | 131 +++++++++++++
 tb/tb_redun_sq_loop.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/redun_sq_loop.sv
// rtl/redun_sq_loop.sv - repeated-squaring controller around redun_mont with carry-resolve output
// Feeds each squarer result back T times, then flattens the redundant words to binary.
module redun_sq_loop #(
  parameter int WRD_BITS = 16,
  parameter int RED_BITS = 17,
  parameter int NUM_WRDS = 64,
  parameter int T_LEN    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic [NUM_WRDS*RED_BITS-1:0] i_dat,
  input  logic [T_LEN-1:0]             i_t,
  input  logic                         i_val,
  output logic                         o_rdy,
  output logic [NUM_WRDS*RED_BITS-1:0] o_sq,
  output logic                         o_sq_val,
  input  logic [NUM_WRDS*RED_BITS-1:0] i_mul,
  input  logic                         i_mul_val,
  output logic [NUM_WRDS*WRD_BITS-1:0] o_dat,
  output logic [T_LEN-1:0]             o_cnt,
  output logic                         o_val,
  input  logic                         i_rdy,
  output logic                         o_ovf,
  output logic                         o_err
);

  localparam int DAT_BITS = NUM_WRDS * WRD_BITS;
  localparam int VEC_BITS = NUM_WRDS * RED_BITS;
  localparam int CRY_BITS = RED_BITS - WRD_BITS + 1;
  localparam int IDX_BITS = (NUM_WRDS > 1) ? $clog2(NUM_WRDS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESOLVE, S_OUT} state_t;

  state_t              r_state, w_next;
  logic [VEC_BITS-1:0] r_res, r_sq;
  logic                r_sq_val;
  logic [T_LEN-1:0]    r_t, r_cnt;
  logic [DAT_BITS-1:0] r_dat;
  logic [IDX_BITS-1:0] r_idx;
  logic [CRY_BITS-1:0] r_cry;
  logic                r_ovf, r_err;

  logic [T_LEN-1:0]    w_cnt_inc;
  logic                w_last, w_idx_last;
  logic [RED_BITS:0]   w_sum;
  logic [CRY_BITS-1:0] w_cry_nxt;

  assign w_cnt_inc  = r_cnt + T_LEN'(1);
  assign w_last     = (w_cnt_inc == r_t);
  assign w_idx_last = (r_idx == IDX_BITS'(NUM_WRDS - 1));
  // r_res shifts down one word per resolve cycle, so the active word is always at the bottom
  assign w_sum      = {1'b0, r_res[RED_BITS-1:0]} + {{(RED_BITS+1-CRY_BITS){1'b0}}, r_cry};
  assign w_cry_nxt  = w_sum[RED_BITS:WRD_BITS];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_val) w_next = (i_t == '0) ? S_RESOLVE : S_ISSUE;
      S_ISSUE:   w_next = S_WAIT;
      S_WAIT:    if (i_mul_val && w_last) w_next = S_RESOLVE;
      S_RESOLVE: if (w_idx_last) w_next = S_OUT;
      S_OUT:     if (i_rdy) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res    <= '0;
      r_sq     <= '0;
      r_sq_val <= 1'b0;
      r_t      <= '0;
      r_cnt    <= '0;
      r_dat    <= '0;
      r_idx    <= '0;
      r_cry    <= '0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_sq_val <= 1'b0;
      if (i_mul_val && r_state != S_WAIT) r_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_val) begin
            r_res    <= i_dat;
            r_sq     <= i_dat;
            r_t      <= i_t;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_cry    <= '0;
            r_sq_val <= (i_t != '0);
          end
        end
        S_WAIT: begin
          if (i_mul_val) begin
            r_res <= i_mul;
            r_cnt <= w_cnt_inc;
            if (!w_last) begin
              r_sq     <= i_mul;
              r_sq_val <= 1'b1;
            end
          end
        end
        S_RESOLVE: begin
          // Resolved words enter at the top; after NUM_WRDS shifts word 0 sits at bit 0
          r_res <= r_res >> RED_BITS;
          r_dat <= {w_sum[WRD_BITS-1:0], r_dat[DAT_BITS-1:WRD_BITS]};
          r_cry <= w_cry_nxt;
          r_idx <= r_idx + IDX_BITS'(1);
          if (w_idx_last && w_cry_nxt != '0) r_ovf <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_rdy    = (r_state == S_IDLE);
  assign o_val    = (r_state == S_OUT);
  assign o_sq     = r_sq;
  assign o_sq_val = r_sq_val;
  assign o_dat    = r_dat;
  assign o_cnt    = r_cnt;
  assign o_ovf    = r_ovf;
  assign o_err    = r_err;

endmodule

// File: tb/tb_redun_sq_loop.sv
// tb/tb_redun_sq_loop.sv - randomized self-checking bench for redun_sq_loop
// A modular-squaring squarer model answers with randomly redundant encodings after a fixed latency.
module tb_redun_sq_loop;
  localparam int W  = 16;
  localparam int R  = 17;
  localparam int N  = 64;
  localparam int TL = 32;
  localparam int DB = N * W;
  localparam int VB = N * R;
  localparam int L  = 3;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [VB-1:0] i_dat;
  logic [TL-1:0] i_t;
  logic          i_val;
  logic          o_rdy;
  logic [VB-1:0] o_sq;
  logic          o_sq_val;
  logic [VB-1:0] i_mul = '0;
  logic          i_mul_val = 1'b0;
  logic [DB-1:0] o_dat;
  logic [TL-1:0] o_cnt;
  logic          o_val;
  logic          i_rdy;
  logic          o_ovf;
  logic          o_err;

  redun_sq_loop dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_dat(i_dat), .i_t(i_t), .i_val(i_val), .o_rdy(o_rdy),
    .o_sq(o_sq), .o_sq_val(o_sq_val), .i_mul(i_mul), .i_mul_val(i_mul_val), .o_dat(o_dat),
    .o_cnt(o_cnt), .o_val(o_val), .i_rdy(i_rdy), .o_ovf(o_ovf), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int failures = 0;
  logic [DB-1:0] modulus;

  int cyc = 0;
  int sq_pulses = 0;
  int fb_ok = 0;
  int last_mul = -10;
  int q_due[$];
  logic [VB-1:0] q_dat[$];

  function automatic logic [DB+79:0] rval(input logic [VB-1:0] r);
    logic [DB+79:0] s = '0;
    for (int k = 0; k < N; k++)
      s += ({{(DB+80-R){1'b0}}, r[k*R +: R]} << (k*W));
    return s;
  endfunction

  function automatic logic [VB-1:0] enc(input logic [DB-1:0] v);
    int w[N];
    logic [VB-1:0] r;
    for (int k = 0; k < N; k++) w[k] = int'(v[k*W +: W]);
    for (int k = 1; k < N; k++)
      if (w[k] > 0 && $urandom_range(1, 0) == 1) begin
        w[k] = w[k] - 1;
        w[k-1] = w[k-1] + 65536;
      end
    for (int k = 0; k < N; k++) r[k*R +: R] = R'(w[k]);
    return r;
  endfunction

  function automatic logic [DB-1:0] sqm(input logic [DB-1:0] a);
    logic [2*DB-1:0] p;
    p = {{DB{1'b0}}, a} * {{DB{1'b0}}, a};
    p = p % {{DB{1'b0}}, modulus};
    return p[DB-1:0];
  endfunction

  function automatic logic [DB-1:0] powsq(input logic [DB-1:0] a, input int t);
    logic [DB-1:0] x = a;
    for (int i = 0; i < t; i++) x = sqm(x);
    return x;
  endfunction

  function automatic logic [DB-1:0] rnd_val();
    logic [DB-1:0] a;
    for (int i = 0; i < DB/32; i++) a[32*i +: 32] = $urandom;
    a[DB-1] = 1'b0;
    return a;
  endfunction

  // Squarer model: answers each o_sq_val exactly L cycles later, survives DUT reset
  always @(negedge i_clk) begin
    logic [DB+79:0] v;
    cyc = cyc + 1;
    i_mul_val = 1'b0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      i_mul = q_dat.pop_front();
      void'(q_due.pop_front());
      i_mul_val = 1'b1;
      last_mul = cyc;
    end
    if (o_sq_val) begin
      sq_pulses++;
      if (last_mul == cyc - 1) fb_ok++;
      v = rval(o_sq) % {80'b0, modulus};
      q_due.push_back(cyc + L);
      q_dat.push_back(enc(sqm(v[DB-1:0])));
    end
  end

  task automatic start_job(input logic [VB-1:0] d, input logic [TL-1:0] t);
    @(negedge i_clk);
    i_dat = d;
    i_t   = t;
    i_val = 1'b1;
    @(negedge i_clk);
    i_val = 1'b0;
  endtask

  task automatic run_job(input logic [VB-1:0] d, input logic [TL-1:0] t,
                         output bit to, output int nsq, output int nfb);
    int sq0 = sq_pulses;
    int fb0 = fb_ok;
    start_job(d, t);
    to = 1'b1;
    for (int i = 0; i < 20000; i++) begin
      if (o_val) begin
        to = 1'b0;
        break;
      end
      @(negedge i_clk);
    end
    nsq = sq_pulses - sq0;
    nfb = fb_ok - fb0;
  endtask

  task automatic test_reset();
    i_rst = 1'b1; i_val = 1'b0; i_rdy = 1'b1; i_t = '0; i_dat = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    checks++;
    if (o_rdy !== 1'b1 || o_sq_val !== 1'b0 || o_val !== 1'b0 || o_ovf !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: rdy=%b sq_val=%b val=%b ovf=%b err=%b, required 1 0 0 0 0",
               o_rdy, o_sq_val, o_val, o_ovf, o_err);
    end
    checks++;
    if (o_dat !== '0 || o_cnt !== '0 || o_sq !== '0) begin
      failures++;
      $display("FAIL reset_data: dat=%h cnt=%0d sq_low=%h, required zeros", o_dat[127:0], o_cnt, o_sq[127:0]);
    end
  endtask

  task automatic test_t0();
    logic [VB-1:0] d = '0;
    bit to; int nsq, nfb;
    d[R-1:0] = 17'h1FFFF;
    d[2*R-1:R] = 17'h00001;
    run_job(d, '0, to, nsq, nfb);
    checks++;
    if (to || o_dat !== DB'(32'h2FFFF) || o_cnt !== '0 || nsq != 0 || o_ovf !== 1'b0) begin
      failures++;
      $display("FAIL t0: to=%b dat=%h cnt=%0d sq=%0d ovf=%b, required dat=2ffff cnt=0 sq=0 ovf=0",
               to, o_dat[127:0], o_cnt, nsq, o_ovf);
    end
    @(negedge i_clk);
  endtask

  task automatic test_t1();
    logic [DB-1:0] a = DB'(5);
    logic [DB-1:0] e = powsq(a, 1);
    bit to; int nsq, nfb;
    run_job(enc(a), TL'(1), to, nsq, nfb);
    checks++;
    if (to || o_dat !== e || o_cnt !== TL'(1) || nsq != 1) begin
      failures++;
      $display("FAIL t1: to=%b dat=%h cnt=%0d sq=%0d, required dat=%h cnt=1 sq=1",
               to, o_dat[127:0], o_cnt, nsq, e[127:0]);
    end
    @(negedge i_clk);
  endtask

  task automatic test_t127();
    logic [DB-1:0] a = rnd_val();
    logic [DB-1:0] e = powsq(a, 127);
    bit to; int nsq, nfb;
    run_job(enc(a), TL'(127), to, nsq, nfb);
    checks++;
    if (to || o_dat !== e) begin
      failures++;
      $display("FAIL t127_dat: to=%b dat=%h, required %h", to, o_dat[127:0], e[127:0]);
    end
    checks++;
    if (o_cnt !== TL'(127) || nsq != 127 || nfb != 126 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL t127_loop: cnt=%0d sq=%0d fb1=%0d err=%b, required 127 127 126 0",
               o_cnt, nsq, nfb, o_err);
    end
    @(negedge i_clk);
  endtask

  task automatic test_backpressure();
    logic [DB-1:0] a = rnd_val();
    logic [DB-1:0] e = powsq(a, 3);
    logic [DB-1:0] snap;
    bit to, bad; int nsq, nfb;
    i_rdy = 1'b0;
    run_job(enc(a), TL'(3), to, nsq, nfb);
    snap = o_dat;
    checks++;
    if (to || snap !== e) begin
      failures++;
      $display("FAIL bp_dat: to=%b dat=%h, required %h", to, snap[127:0], e[127:0]);
    end
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      i_dat = enc(rnd_val());
      i_t   = TL'(i);
      i_val = 1'b1;
      @(negedge i_clk);
      if (o_val !== 1'b1 || o_dat !== snap || o_rdy !== 1'b0 || o_cnt !== TL'(3)) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold: val=%b rdy=%b cnt=%0d dat=%h, required 1 0 3 %h",
               o_val, o_rdy, o_cnt, o_dat[127:0], snap[127:0]);
    end
    i_val = 1'b0;
    i_rdy = 1'b1;
    @(negedge i_clk);
    checks++;
    if (o_val !== 1'b0 || o_rdy !== 1'b1 || o_cnt !== TL'(3)) begin
      failures++;
      $display("FAIL bp_release: val=%b rdy=%b cnt=%0d, required 0 1 3", o_val, o_rdy, o_cnt);
    end
  endtask

  task automatic test_ovf();
    logic [VB-1:0] d;
    logic [DB+79:0] v;
    logic [DB-1:0] e;
    bit to; int nsq, nfb;
    for (int k = 0; k < N; k++) d[k*R +: R] = 17'h1FFFF;
    v = rval(d);
    run_job(d, '0, to, nsq, nfb);
    checks++;
    if (to || o_dat !== v[DB-1:0] || o_ovf !== (|v[DB+79:DB]) || o_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_set: to=%b dat=%h ovf=%b, required dat=%h ovf=1",
               to, o_dat[127:0], o_ovf, v[127:0]);
    end
    @(negedge i_clk);
    e = powsq(DB'(3), 1);
    run_job(enc(DB'(3)), TL'(1), to, nsq, nfb);
    checks++;
    if (to || o_dat !== e || o_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_sticky: to=%b dat=%h ovf=%b, required dat=%h ovf=1", to, o_dat[127:0], o_ovf, e[127:0]);
    end
    @(negedge i_clk);
  endtask

  task automatic test_random();
    for (int j = 0; j < 4; j++) begin
      logic [DB-1:0] a = rnd_val();
      int t = $urandom_range(6, 0);
      logic [DB-1:0] e = powsq(a, t);
      bit to; int nsq, nfb;
      run_job(enc(a), TL'(t), to, nsq, nfb);
      checks++;
      if (to || o_dat !== e || o_cnt !== TL'(t) || nsq != t) begin
        failures++;
        $display("FAIL random_%0d: to=%b t=%0d dat=%h cnt=%0d sq=%0d, required dat=%h",
                 j, to, t, o_dat[127:0], o_cnt, nsq, e[127:0]);
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset_mid();
    logic [DB-1:0] a = rnd_val();
    logic [DB-1:0] e;
    bit to, hit; int nsq, nfb;
    start_job(enc(a), TL'(50));
    hit = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge i_clk);
      if (o_cnt >= TL'(3) && o_sq_val) begin
        hit = 1'b1;
        break;
      end
    end
    i_rst = 1'b1;
    #1;
    checks++;
    if (!hit || o_rdy !== 1'b1 || o_sq_val !== 1'b0 || o_sq !== '0 || o_dat !== '0 ||
        o_cnt !== '0 || o_val !== 1'b0 || o_ovf !== 1'b0 || o_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset: hit=%b rdy=%b sq_val=%b cnt=%0d val=%b ovf=%b err=%b, required 1 1 0 0 0 0 0",
               hit, o_rdy, o_sq_val, o_cnt, o_val, o_ovf, o_err);
    end
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int i = 0; i < 20 && o_err !== 1'b1; i++) @(negedge i_clk);
    checks++;
    if (o_err !== 1'b1) begin
      failures++;
      $display("FAIL stray_err: err=%b, required 1", o_err);
    end
    for (int i = 0; i < 20 && q_due.size() > 0; i++) @(negedge i_clk);
    a = rnd_val();
    e = powsq(a, 2);
    run_job(enc(a), TL'(2), to, nsq, nfb);
    checks++;
    if (to || o_dat !== e || o_cnt !== TL'(2) || nsq != 2 || o_err !== 1'b1) begin
      failures++;
      $display("FAIL after_reset: to=%b dat=%h cnt=%0d sq=%0d err=%b, required dat=%h cnt=2 sq=2 err=1",
               to, o_dat[127:0], o_cnt, nsq, o_err, e[127:0]);
    end
    @(negedge i_clk);
  endtask

  initial begin
    for (int i = 0; i < DB/32; i++) modulus[32*i +: 32] = $urandom;
    modulus[DB-1] = 1'b1;
    modulus[0] = 1'b1;
    test_reset();
    test_t0();
    test_t1();
    test_t127();
    test_backpressure();
    test_ovf();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
